// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - multi-cycle radix-4 Booth multiplier with early termination
module booth_multiplier_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic             abort_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic [WIDTH-1:0] product_low_o,
    output logic [WIDTH-1:0] product_high_o,
    output logic [CNT_W-1:0] digits_o
);

    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int DMAX = (WIDTH + 2) / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [EW-1:0]      a_ext;
    logic [EW-1:0]      b_ext;
    logic [AW-1:0]      acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   digits_q;

    logic [EW:0]        b_pad;
    logic [2:0]         win;
    logic [EW:0]        pp;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      acc_next;
    logic [CNT_W:0]     d_next;
    logic [CNT_W+1:0]   shamt;
    logic signed [EW-1:0] b_sh;
    logic               last_digit;

    // Recode the current Booth window, form the partial product and decide whether the remaining digits are all zero
    always_comb begin
        b_pad  = {b_ext, 1'b0};
        win    = b_pad[{cnt, 1'b0} +: 3];
        pp     = '0;
        case (win)
            3'b001, 3'b010: pp = {a_ext[EW-1], a_ext};
            3'b011:         pp = {a_ext, 1'b0};
            3'b100:         pp = -{a_ext, 1'b0};
            3'b101, 3'b110: pp = -{a_ext[EW-1], a_ext};
            default:        pp = '0;
        endcase
        pp_ext   = {{(WIDTH + 1){pp[EW]}}, pp};
        acc_next = acc + (pp_ext << {cnt, 1'b0});
        d_next   = {1'b0, cnt} + (CNT_W + 1)'(1);
        // Bits from 2D-1 upward all equal means every later window is 000 or 111
        shamt      = {d_next, 1'b0} - (CNT_W + 2)'(1);
        b_sh       = $signed(b_ext) >>> shamt;
        last_digit = (b_sh == '0) || (&b_sh) || (d_next == (CNT_W + 1)'(DMAX));
    end

    // Control FSM plus operand, accumulator and result registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= S_IDLE;
            a_ext    <= '0;
            b_ext    <= '0;
            acc      <= '0;
            cnt      <= '0;
            prod_q   <= '0;
            digits_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid_i) begin
                        a_ext <= {{2{signed_i & multiplicand_i[WIDTH-1]}}, multiplicand_i};
                        b_ext <= {{2{signed_i & multiplier_i[WIDTH-1]}}, multiplier_i};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        if (last_digit) begin
                            prod_q   <= acc_next[2*WIDTH-1:0];
                            digits_q <= d_next[CNT_W-1:0];
                            state    <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (abort_i || done_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign start_ready_o  = (state == S_IDLE);
    assign done_valid_o   = (state == S_DONE);
    assign product_low_o  = prod_q[WIDTH-1:0];
    assign product_high_o = prod_q[2*WIDTH-1:WIDTH];
    assign digits_o       = digits_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed and randomised checks of booth_multiplier_seq
module tb_booth_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        sv, sg, ab, dr;
    logic [63:0] ma, mb;
    logic        sr, dv;
    logic [63:0] lo, hi;
    logic [5:0]  dg;

    logic        sv8, sg8, ab8, dr8;
    logic [7:0]  ma8, mb8;
    logic        sr8, dv8;
    logic [7:0]  lo8, hi8;
    logic [2:0]  dg8;

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(64), .CNT_W(6)) u_dut (
        .clk(clk), .reset_n_i(rst_n), .start_valid_i(sv), .start_ready_o(sr),
        .signed_i(sg), .multiplicand_i(ma), .multiplier_i(mb), .abort_i(ab),
        .done_valid_o(dv), .done_ready_i(dr), .product_low_o(lo),
        .product_high_o(hi), .digits_o(dg)
    );

    booth_multiplier_seq #(.WIDTH(8), .CNT_W(3)) u_dut8 (
        .clk(clk), .reset_n_i(rst_n), .start_valid_i(sv8), .start_ready_o(sr8),
        .signed_i(sg8), .multiplicand_i(ma8), .multiplier_i(mb8), .abort_i(ab8),
        .done_valid_o(dv8), .done_ready_i(dr8), .product_low_o(lo8),
        .product_high_o(hi8), .digits_o(dg8)
    );

    task automatic run_op64(input logic s, input logic [63:0] a, input logic [63:0] b, output int lat);
        @(posedge clk); #1;
        sv = 1'b1; sg = s; ma = a; mb = b;
        @(posedge clk); #1;
        sv = 1'b0; ma = ~a; mb = ~b; sg = ~s;
        lat = 0;
        while (!dv && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release64();
        dr = 1'b1;
        @(posedge clk); #1;
        dr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (sr !== 1'b1 || dv !== 1'b0 || lo !== 64'd0 || hi !== 64'd0 || dg !== 6'd0) begin
            errors++;
            $display("FAIL reset64 sr=%b dv=%b lo=%h hi=%h dg=%0d required sr=1 dv=0 lo=0 hi=0 dg=0", sr, dv, lo, hi, dg);
        end
        checks++;
        if (sr8 !== 1'b1 || dv8 !== 1'b0 || lo8 !== 8'd0 || hi8 !== 8'd0 || dg8 !== 3'd0) begin
            errors++;
            $display("FAIL reset8 sr=%b dv=%b lo=%h hi=%h dg=%0d required sr=1 dv=0 lo=0 hi=0 dg=0", sr8, dv8, lo8, hi8, dg8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_unsigned();
        int lat;
        run_op64(1'b0, 64'd5, 64'd3, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d required 2", lat); end
        checks++;
        if (lo !== 64'd15 || hi !== 64'd0) begin errors++; $display("FAIL basic_product got %h_%h required 0_f", hi, lo); end
        checks++;
        if (dg !== 6'd2) begin errors++; $display("FAIL basic_digits got %0d required 2", dg); end
        release64();
        checks++;
        if (dv !== 1'b0 || sr !== 1'b1) begin errors++; $display("FAIL basic_release dv=%b sr=%b required dv=0 sr=1", dv, sr); end
    endtask

    task automatic test_unsigned_max();
        int lat;
        run_op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        checks++;
        if (lat !== 33 || dg !== 6'd33) begin errors++; $display("FAIL umax_digits lat=%0d dg=%0d required 33", lat, dg); end
        checks++;
        if (hi !== 64'hFFFF_FFFF_FFFF_FFFE || lo !== 64'h1) begin
            errors++; $display("FAIL umax_product got %h_%h required fffffffffffffffe_0000000000000001", hi, lo);
        end
        release64();
    endtask

    task automatic test_signed();
        int lat;
        run_op64(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        checks++;
        if (lat !== 1 || dg !== 6'd1) begin errors++; $display("FAIL sneg_digits lat=%0d dg=%0d required 1", lat, dg); end
        checks++;
        if (lo !== 64'd7 || hi !== 64'd0) begin errors++; $display("FAIL sneg_product got %h_%h required 0_7", hi, lo); end
        release64();
        run_op64(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, lat);
        checks++;
        if (hi !== 64'h4000_0000_0000_0000 || lo !== 64'd0) begin
            errors++; $display("FAIL smin_product got %h_%h required 4000000000000000_0", hi, lo);
        end
        checks++;
        if (lat !== 32 || dg !== 6'd32) begin errors++; $display("FAIL smin_digits lat=%0d dg=%0d required 32", lat, dg); end
        release64();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op64(1'b0, 64'd5, 64'd3, lat);
        for (int i = 0; i < 10; i++) begin
            sv = 1'b1; sg = 1'b0; ma = 64'd9; mb = 64'd9;
            @(posedge clk); #1;
            checks++;
            if (dv !== 1'b1 || sr !== 1'b0 || lo !== 64'd15 || hi !== 64'd0 || dg !== 6'd2) begin
                errors++;
                $display("FAIL hold_cycle%0d dv=%b sr=%b lo=%h dg=%0d required dv=1 sr=0 lo=f dg=2", i, dv, sr, lo, dg);
            end
        end
        sv = 1'b0;
        release64();
        checks++;
        if (dv !== 1'b0 || sr !== 1'b1 || lo !== 64'd15 || dg !== 6'd2) begin
            errors++; $display("FAIL hold_release dv=%b sr=%b lo=%h dg=%0d required dv=0 sr=1 lo=f dg=2", dv, sr, lo, dg);
        end
        sv = 1'b1; sg = 1'b0; ma = 64'd2; mb = 64'd2;
        @(posedge clk); #1;
        sv = 1'b0;
        checks++;
        if (sr !== 1'b0) begin errors++; $display("FAIL turnaround_accept sr=%b required 0", sr); end
        lat = 0;
        while (!dv && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 2 || lo !== 64'd4 || hi !== 64'd0 || dg !== 6'd2) begin
            errors++; $display("FAIL turnaround_result lat=%0d lo=%h dg=%0d required lat=2 lo=4 dg=2", lat, lo, dg);
        end
        release64();
    endtask

    task automatic test_abort_reset();
        bit seen;
        @(posedge clk); #1;
        sv = 1'b1; sg = 1'b0; ma = '1; mb = '1;
        @(posedge clk); #1;
        sv = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        ab = 1'b1;
        @(posedge clk); #1;
        ab = 1'b0;
        checks++;
        if (dv !== 1'b0 || sr !== 1'b1 || lo !== 64'd4 || hi !== 64'd0 || dg !== 6'd2) begin
            errors++; $display("FAIL abort_state dv=%b sr=%b lo=%h dg=%0d required dv=0 sr=1 lo=4 dg=2", dv, sr, lo, dg);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (dv) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done saw done_valid=%b required 0", seen); end
        sv = 1'b1; sg = 1'b0; ma = '1; mb = '1;
        @(posedge clk); #1;
        sv = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sr !== 1'b1 || dv !== 1'b0 || lo !== 64'd0 || hi !== 64'd0 || dg !== 6'd0) begin
            errors++; $display("FAIL midop_reset sr=%b dv=%b lo=%h hi=%h dg=%0d required sr=1 dv=0 lo=0 hi=0 dg=0", sr, dv, lo, hi, dg);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (dv) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0 || sr !== 1'b1) begin errors++; $display("FAIL reset_no_done dv_seen=%b sr=%b required 0 1", seen, sr); end
    endtask

    function automatic int exp_digits8(input logic s, input logic [7:0] b);
        logic [9:0] ext;
        int t, n;
        ext = {s & b[7], s & b[7], b};
        for (int d = 1; d <= 5; d++) begin
            n = 11 - 2 * d;
            t = int'(ext) >> (2 * d - 1);
            if (t == 0 || t == (1 << n) - 1) return d;
        end
        return 5;
    endfunction

    task automatic test_random_w8();
        logic [7:0]  a, b;
        logic [15:0] ax, bx, ep;
        int          ed, lat;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 2000; i++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                if (i == 0) begin a = 8'h80; b = 8'h80; end
                if (i == 1) begin a = 8'hFF; b = 8'hFF; end
                if (i == 2) begin a = 8'h7F; b = 8'h80; end
                ax = (m == 1) ? {{8{a[7]}}, a} : {8'h00, a};
                bx = (m == 1) ? {{8{b[7]}}, b} : {8'h00, b};
                ep = ax * bx;
                ed = exp_digits8(m[0], b);
                @(posedge clk); #1;
                sv8 = 1'b1; sg8 = m[0]; ma8 = a; mb8 = b;
                @(posedge clk); #1;
                sv8 = 1'b0; ma8 = ~a; mb8 = ~b;
                lat = 0;
                while (!dv8 && lat < 20) begin @(posedge clk); #1; lat++; end
                checks++;
                if ({hi8, lo8} !== ep) begin
                    errors++; $display("FAIL w8_product mode=%0d a=%h b=%h got %h required %h", m, a, b, {hi8, lo8}, ep);
                end
                checks++;
                if (int'(dg8) !== ed || lat !== ed) begin
                    errors++; $display("FAIL w8_digits mode=%0d b=%h got dg=%0d lat=%0d required %0d", m, b, dg8, lat, ed);
                end
                dr8 = 1'b1;
                @(posedge clk); #1;
                dr8 = 1'b0;
            end
        end
    endtask

    initial begin
        sv = 1'b0; sg = 1'b0; ab = 1'b0; dr = 1'b0; ma = '0; mb = '0;
        sv8 = 1'b0; sg8 = 1'b0; ab8 = 1'b0; dr8 = 1'b0; ma8 = '0; mb8 = '0;
        test_reset();
        test_basic_unsigned();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_abort_reset();
        test_random_w8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
